// File: rtl/decomposable_lzc_pipe.sv
// Two-stage, precision-decomposable leading-zero / run-length counter feeding the decomposable shifters.
// Optional input skid buffer (registered in_ready) enabled by defining DECOMPOSABLE_LZC_SKID_EN.
package pe_pkg;
  localparam int PRECISION_CONFIG_L = 2;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

module decomposable_lzc_pipe
  import pe_pkg::*;
#(
  parameter int RUN_DETECT     = 0,
  parameter int EACH_SLICE_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in,
  input  logic [PRECISION_CONFIG_L-1:0] mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0][4:0]               shift_val,
  output logic                          full_shift,
  output logic [3:0]                    zero_lane,
  output logic [PRECISION_CONFIG_L-1:0] out_mode
);

  localparam int SL = EACH_SLICE_LEN;
  localparam logic [3:0] SLICE_FULL = 4'(SL);

  function automatic logic [3:0] lead_count(input logic [SL-1:0] s, input logic b);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int k = SL - 1; k >= 0; k--) begin
      if (run && (s[k] == b)) n = n + 4'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

  logic                          r_s1_valid;
  logic [PRECISION_CONFIG_L-1:0] r_s1_mode;
  logic [3:0][3:0]               r_s1_part;
  logic                          r_out_valid;
  logic [3:0][4:0]               r_shift_val;
  logic                          r_full_shift;
  logic [3:0]                    r_zero_lane;
  logic [PRECISION_CONFIG_L-1:0] r_out_mode;

  logic                          w_s2_load;
  logic                          w_s1_ready;
  logic                          w_src_valid;
  logic [31:0]                   w_src_data;
  logic [PRECISION_CONFIG_L-1:0] w_src_mode;

  assign w_s2_load  = !r_out_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_load;

`ifdef DECOMPOSABLE_LZC_SKID_EN
  logic                          r_skid_valid;
  logic                          r_in_ready;
  logic [31:0]                   r_skid_data;
  logic [PRECISION_CONFIG_L-1:0] r_skid_mode;

  assign in_ready    = r_in_ready;
  assign w_src_valid = r_skid_valid || in_valid;
  assign w_src_data  = r_skid_valid ? r_skid_data : in;
  assign w_src_mode  = r_skid_valid ? r_skid_mode : mode;

  // The skid catches an item accepted on a cycle where stage 1 could not take it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_skid_data  <= '0;
      r_skid_mode  <= PRECISION_CONFIG_32B;
    end else if (r_skid_valid) begin
      if (w_s1_ready) begin
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (in_valid && r_in_ready && !w_s1_ready) begin
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
      r_skid_data  <= in;
      r_skid_mode  <= mode;
    end
  end
`else
  assign in_ready    = w_s1_ready;
  assign w_src_valid = in_valid;
  assign w_src_data  = in;
  assign w_src_mode  = mode;
`endif

  logic [3:0]      w_lane_msb;
  logic [3:0][3:0] w_part;

  // In run-detect mode every slice compares against its owning lane's MSB.
  always_comb begin
    w_lane_msb = '0;
    w_part     = '0;
    for (int i = 0; i < 4; i++) begin
      case (w_src_mode)
        PRECISION_CONFIG_32B: w_lane_msb[i] = w_src_data[31];
        PRECISION_CONFIG_16B: w_lane_msb[i] = (i >= 2) ? w_src_data[31] : w_src_data[15];
        default:              w_lane_msb[i] = w_src_data[SL*i + SL - 1];
      endcase
      w_part[i] = lead_count(w_src_data[SL*i +: SL], (RUN_DETECT != 0) ? w_lane_msb[i] : 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= PRECISION_CONFIG_32B;
      r_s1_part  <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= w_src_valid;
      if (w_src_valid) begin
        r_s1_mode <= w_src_mode;
        r_s1_part <= w_part;
      end
    end
  end

  logic [5:0]      w_c32;
  logic [4:0]      w_hi;
  logic [4:0]      w_lo;
  logic [3:0][4:0] w_shift;
  logic [3:0]      w_zero;

  // A slice only extends its lane's count when every bit above it was part of the run.
  always_comb begin
    w_c32 = {2'b00, r_s1_part[3]};
    if (r_s1_part[3] == SLICE_FULL) begin
      w_c32 = w_c32 + {2'b00, r_s1_part[2]};
      if (r_s1_part[2] == SLICE_FULL) begin
        w_c32 = w_c32 + {2'b00, r_s1_part[1]};
        if (r_s1_part[1] == SLICE_FULL) w_c32 = w_c32 + {2'b00, r_s1_part[0]};
      end
    end
    w_hi = {1'b0, r_s1_part[3]} + ((r_s1_part[3] == SLICE_FULL) ? {1'b0, r_s1_part[2]} : 5'd0);
    w_lo = {1'b0, r_s1_part[1]} + ((r_s1_part[1] == SLICE_FULL) ? {1'b0, r_s1_part[0]} : 5'd0);
    w_shift = '0;
    w_zero  = '0;
    case (r_s1_mode)
      PRECISION_CONFIG_32B: begin
        if (w_c32 == 6'd32) begin
          w_zero  = 4'b1111;
          w_shift = {4{5'd31}};
        end else begin
          w_shift = {4{w_c32[4:0]}};
        end
      end
      PRECISION_CONFIG_16B: begin
        if (w_hi == 5'd16) begin
          w_zero[3:2] = 2'b11;
          w_shift[3]  = 5'd15;
          w_shift[2]  = 5'd15;
        end else begin
          w_shift[3] = w_hi;
          w_shift[2] = w_hi;
        end
        if (w_lo == 5'd16) begin
          w_zero[1:0] = 2'b11;
          w_shift[1]  = 5'd15;
          w_shift[0]  = 5'd15;
        end else begin
          w_shift[1] = w_lo;
          w_shift[0] = w_lo;
        end
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          if (r_s1_part[i] == SLICE_FULL) begin
            w_zero[i]  = 1'b1;
            w_shift[i] = 5'd7;
          end else begin
            w_shift[i] = {1'b0, r_s1_part[i]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_shift_val  <= '0;
      r_zero_lane  <= '0;
      r_full_shift <= 1'b0;
      r_out_mode   <= PRECISION_CONFIG_32B;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_shift_val  <= w_shift;
        r_zero_lane  <= w_zero;
        r_full_shift <= (r_s1_mode == PRECISION_CONFIG_32B) && (w_zero == 4'b1111);
        r_out_mode   <= r_s1_mode;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign shift_val  = r_shift_val;
  assign zero_lane  = r_zero_lane;
  assign full_shift = r_full_shift;
  assign out_mode   = r_out_mode;

endmodule

// File: tb/tb_decomposable_lzc_pipe.sv
// Scoreboard bench for decomposable_lzc_pipe: directed vectors, backpressure, reset flush, random traffic.
module tb_decomposable_lzc_pipe;
  import pe_pkg::*;

  localparam int RUN_DETECT = 0;
`ifdef DECOMPOSABLE_LZC_SKID_EN
  localparam int CAPACITY = 3;
`else
  localparam int CAPACITY = 2;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [31:0]                   in_data = '0;
  logic [PRECISION_CONFIG_L-1:0] mode = PRECISION_CONFIG_32B;
  logic                          out_valid;
  logic                          out_ready = 1'b0;
  logic [3:0][4:0]               shift_val;
  logic                          full_shift;
  logic [3:0]                    zero_lane;
  logic [PRECISION_CONFIG_L-1:0] out_mode;

  typedef struct packed {
    logic [3:0][4:0] sv;
    logic [3:0]      zl;
    logic            fs;
    logic [1:0]      md;
  } resultT;

  typedef struct {
    resultT res;
    int     acceptCycle;
    bit     checkLat;
  } expT;

  expT scoreboard[$];
  int  errors = 0;
  int  checks = 0;
  int  cycle = 0;
  bit  latCheckEn = 1'b0;
  bit  randomReady = 1'b0;

  decomposable_lzc_pipe #(.RUN_DETECT(RUN_DETECT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .shift_val(shift_val),
    .full_shift(full_shift), .zero_lane(zero_lane), .out_mode(out_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: walk each lane bit by bit from its MSB, then replicate over its slices.
  function automatic resultT model(input logic [31:0] d, input logic [1:0] m);
    resultT r;
    int     w, cnt;
    logic   cmp;
    bit     run, z;
    r    = '0;
    r.md = m;
    w = (m == PRECISION_CONFIG_32B) ? 32 : (m == PRECISION_CONFIG_16B) ? 16 : 8;
    for (int l = 0; l < 32 / w; l++) begin
      cmp = (RUN_DETECT != 0) ? d[l*w + w - 1] : 1'b0;
      cnt = 0;
      run = 1'b1;
      for (int b = l*w + w - 1; b >= l*w; b--) begin
        if (run && d[b] == cmp) cnt++;
        else run = 1'b0;
      end
      z = (cnt == w);
      for (int s = l*w/8; s < (l+1)*w/8; s++) begin
        r.sv[s] = z ? 5'(w - 1) : 5'(cnt);
        r.zl[s] = z;
      end
    end
    r.fs = (m == PRECISION_CONFIG_32B) && (r.zl == 4'hF);
    return r;
  endfunction

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    logic [7:0]  by;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      case ($urandom % 5)
        0: by = 8'h00;
        1: by = 8'h01 << $urandom_range(0, 7);
        2: by = 8'hFF;
        default: by = 8'($urandom);
      endcase
      w[8*b +: 8] = by;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at a later negedge with in_valid low.
  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m, input int maxWait,
                               output bit accepted);
    expT e;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    accepted = 1'b0;
    for (int k = 0; k < maxWait && !accepted; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (in_ready) begin
        accepted      = 1'b1;
        e.res         = model(d, m);
        e.acceptCycle = cycle;
        e.checkLat    = latCheckEn;
        scoreboard.push_back(e);
      end
    end
    if (accepted) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    resultT act;
    expT    e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        act = {shift_val, zero_lane, full_shift, out_mode};
        if (scoreboard.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0h expected none", act);
        end else begin
          e = scoreboard.pop_front();
          checkOutput("result", 32'(act), 32'(e.res));
          if (e.checkLat) checkOutput("latency", 32'(cycle - e.acceptCycle), 32'd2);
        end
      end
    end
  end

  always @(negedge clk) if (randomReady) out_ready = ($urandom % 4) != 0;

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0]     tpData [4];
    logic [1:0]      tpMode [4];
    logic [3:0][4:0] tpSv   [4];
    logic [3:0]      tpZl   [4];
    logic            tpFs   [4];
    resultT          snap;
    bit              acc;
    int              nAcc, waitCnt;

    tpData[0] = 32'h0001_0000; tpMode[0] = PRECISION_CONFIG_32B;
    tpSv[0] = {5'd15, 5'd15, 5'd15, 5'd15}; tpZl[0] = 4'b0000; tpFs[0] = 1'b0;
    tpData[1] = 32'h0000_0000; tpMode[1] = PRECISION_CONFIG_32B;
    tpSv[1] = {5'd31, 5'd31, 5'd31, 5'd31}; tpZl[1] = 4'b1111; tpFs[1] = 1'b1;
    tpData[2] = 32'h0080_0003; tpMode[2] = PRECISION_CONFIG_16B;
    tpSv[2] = {5'd8, 5'd8, 5'd14, 5'd14}; tpZl[2] = 4'b0000; tpFs[2] = 1'b0;
    tpData[3] = 32'h8001_0010; tpMode[3] = PRECISION_CONFIG_8B;
    tpSv[3] = {5'd0, 5'd7, 5'd7, 5'd3}; tpZl[3] = 4'b0010; tpFs[3] = 1'b0;

    $display("[TB] reset");
    idle(2);
    #2;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_shift_val", 32'(shift_val), 32'd0);
    checkOutput("reset_zero_lane", 32'(zero_lane), 32'd0);
    checkOutput("reset_full_shift", 32'(full_shift), 32'd0);
    checkOutput("reset_out_mode", 32'(out_mode), 32'(PRECISION_CONFIG_32B));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("[TB] directed vectors");
    out_ready  = 1'b1;
    latCheckEn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      applyStimulus(tpData[t], tpMode[t], 5, acc);
      checkOutput("tp_accept", 32'(acc), 32'd1);
      #2;
      checkOutput("tp_not_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      #2;
      checkOutput("tp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("tp_shift_val", 32'(shift_val), 32'(tpSv[t]));
      checkOutput("tp_zero_lane", 32'(zero_lane), 32'(tpZl[t]));
      checkOutput("tp_full_shift", 32'(full_shift), 32'(tpFs[t]));
      checkOutput("tp_out_mode", 32'(out_mode), 32'(tpMode[t]));
      idle(2);
    end
    latCheckEn = 1'b0;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    nAcc = 0;
    for (int t = 0; t < CAPACITY + 1; t++) begin
      applyStimulus(randWord(), 2'($urandom_range(0, 2)), 4, acc);
      if (acc) nAcc++;
      else @(negedge clk);
    end
    checkOutput("capacity", 32'(nAcc), 32'(CAPACITY));
    #2;
    snap = {shift_val, zero_lane, full_shift, out_mode};
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      checkOutput("stall_valid_hold", 32'(out_valid), 32'd1);
      checkOutput("stall_data_hold", 32'({shift_val, zero_lane, full_shift, out_mode}), 32'(snap));
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < CAPACITY; k++) begin
      #2;
      checkOutput("drain_no_bubble", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    #2;
    checkOutput("drain_empty", 32'(out_valid), 32'd0);
    checkOutput("drain_scoreboard", 32'(scoreboard.size()), 32'd0);
    @(negedge clk);

    $display("[TB] reset flush");
    out_ready = 1'b0;
    applyStimulus(32'h0000_00F0, PRECISION_CONFIG_8B, 4, acc);
    applyStimulus(32'h0F00_0000, PRECISION_CONFIG_32B, 4, acc);
    rst_n = 1'b0;
    scoreboard.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_shift_val", 32'(shift_val), 32'd0);
    checkOutput("flush_zero_lane", 32'(zero_lane), 32'd0);
    checkOutput("flush_out_mode", 32'(out_mode), 32'(PRECISION_CONFIG_32B));
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(3);
    #2;
    checkOutput("flush_no_ghost", 32'(out_valid), 32'd0);
    @(negedge clk);
    latCheckEn = 1'b1;
    applyStimulus(32'h0000_1234, PRECISION_CONFIG_16B, 4, acc);
    checkOutput("flush_accept", 32'(acc), 32'd1);
    idle(3);
    latCheckEn = 1'b0;

    $display("[TB] random traffic");
    randomReady = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom % 4 == 0) @(negedge clk);
      applyStimulus(randWord(), 2'($urandom_range(0, 2)), 40, acc);
      if (!acc) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got in_ready=0 expected acceptance");
        @(negedge clk);
      end
    end
    randomReady = 1'b0;
    out_ready = 1'b1;
    waitCnt = 0;
    while (scoreboard.size() != 0 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    idle(2);
    checkOutput("final_scoreboard_empty", 32'(scoreboard.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decomposable_lzc_pipe.md
Name: decomposable_lzc_pipe

Overview:
- Pipelined, precision-decomposable leading-count unit. It is the producer of shift amounts for the decomposable left/right shifters.
- Takes a 32-bit word split into lanes per `mode` (1×32, 2×16 or 4×8). Returns per-8-bit-slice `shift_val` in exactly the `[3:0][4:0]` format the shifters consume, plus zero flags.
- Sits in the posit decode/normalize path ahead of the shifters, with a valid/ready handshake on both sides.

Parameters:
- RUN_DETECT, 0: 0 = count leading zeros per lane; 1 = count leading bits equal to the lane MSB (posit regime run length).
- EACH_SLICE_LEN, 8: slice width; fixed at 8, not parameterizable beyond that.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  input item present.
- in_ready  output  1  block can accept an input item this cycle.
- in  input  32  data word; lane MSB is the highest bit of each lane.
- mode  input  PRECISION_CONFIG_L  pe_pkg::PRECISION_CONFIG_32B/16B/8B; sampled with `in`.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- shift_val  output  [3:0][4:0]  per-slice shift amount; entry i serves bits `[8i+7:8i]`.
- full_shift  output  1  32B mode and whole word is zero (or uniform, RUN_DETECT=1).
- zero_lane  output  4  per-slice flag: the owning lane had no terminating bit.
- out_mode  output  PRECISION_CONFIG_L  mode of the item on the output.

Behaviour:
- Stage 1 (registered): captures `in`, `mode`, and four per-slice partial counts, 0..8 each. For RUN_DETECT=1 the compare bit is the owning lane's MSB, not the slice MSB.
- Stage 2 (registered): combines partial counts by mode.
  - 32B: c = p3, then +p2 if p3==8, and so on down the slices.
  - 16B: hi = p3(+p2 if p3==8); lo = p1(+p0 if p1==8).
  - 8B: each slice is independent.
- Lane count saturates at lane_width-1 (31/15/7). When a lane has no terminating bit, its `zero_lane` bits are set and `shift_val` = lane_width-1.
- `shift_val` replication:
  - 32B: all four entries = c.
  - 16B: entries [3],[2] = hi; entries [1],[0] = lo.
  - 8B: entry i = slice i.
- `full_shift` = 1 only in 32B with `zero_lane` = 4'b1111; otherwise 0.
- Latency is exactly 2 cycles from input acceptance to `out_valid` while `out_ready`=1. Throughput is 1 item/cycle. There is no combinational path from `in` to any output.
- Handshake:
  - Transfer occurs on valid&ready.
  - Stage 2 loads when empty or `out_ready`=1.
  - Stage 1 advances when stage 2 loads.
  - `in_ready` = !s1_valid || s1_advance.
- Stall rule: while `out_valid`=1 and `out_ready`=0, all outputs hold stable and `out_valid` stays 1. The pipeline holds at most 2 items; items leave in order.
- Mode may change every item; each item carries its own mode (`out_mode`).
- Reset: on rst_n=0 at a clock edge, `out_valid`=0, all data outputs=0, `out_mode`=PRECISION_CONFIG_32B, internal valids=0, and in-flight items are discarded. `in_ready`=1 in the first cycle after reset is released.
- Simultaneous accept and drain with the pipe full: legal, with no bubble inserted.

Optional Feature:
- Macro: DECOMPOSABLE_LZC_SKID_EN.
- Defined: adds a 1-entry skid buffer at the input, and `in_ready` becomes a pure register output with no combinational dependence on `out_ready`. Capacity rises to 3 items. Latency is unchanged when the skid is empty; an item is delayed 1 cycle when it passes through the skid.
- Undefined: `in_ready` is combinational from `out_ready` as described above; capacity is 2.

Test Plan:
- 32B, in=0x0001_0000, out_ready=1 -> 2 cycles later `out_valid`=1; `shift_val`={15,15,15,15}; `zero_lane`=0; `full_shift`=0.
- 32B, in=0x0000_0000 -> `shift_val`={31,31,31,31}; `zero_lane`=4'b1111; `full_shift`=1.
- 16B, in=0x0080_0003 -> `shift_val`={8,8,14,14}; `zero_lane`=0; `out_mode`=16B.
- 8B, in=0x8001_0010 -> `shift_val`={0,7,7,3}; `zero_lane`=4'b0010; `full_shift`=0.
- Backpressure: out_ready=0, offer 3 items back-to-back -> only 2 accepted (3 with DECOMPOSABLE_LZC_SKID_EN); outputs stable while stalled. Then out_ready=1 -> all items delivered in order, one per cycle.
- rst_n=0 for 1 cycle with 2 items in flight -> next cycle `out_valid`=0 and outputs 0; the items never appear. A new item after release emerges with 2-cycle latency.
